cut_vector_sequencer: RTL and testbench

//  Sequences stimulus into a combinational circuit-under-test (CUT, e.g. an ISCAS85 netlist, 41 in / 32 out)
//  for aging/stress runs: replays a loaded vector table onto the CUT, waits a settle window, captures CUT outputs.

---
 rtl/cut_seq_pkg.sv | 24 ++
 rtl/cut_seq_misr.sv | 30 +++
 rtl/cut_vector_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cut_vector_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cut_seq_pkg.sv
// Shared types and constants for the CUT vector sequencer.
// FSM state encoding, pass counter width and the MISR feedback polynomial.
package cut_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int PASS_W = 16;

    // x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

    function automatic logic [PASS_W-1:0] sat_inc(
        input logic [PASS_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cut_seq_misr.sv
// Multiple-input signature register folding CUT responses into a signature.
// Cleared on run start; updated once per capture.
module cut_seq_misr
    import cut_seq_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] sig
);

    localparam logic [OUT_W-1:0] TAPS = OUT_W'(MISR_TAPS);

    logic fb;

    assign fb = ^(sig & TAPS);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[OUT_W-2:0], fb} ^ din;
        end
    end

endmodule

// File: rtl/cut_vector_sequencer.sv
// Replays a vector table onto a combinational CUT, waits, captures responses.
// Define CUT_SEQ_MISR_EN to build the response-signature MISR.
module cut_vector_sequencer
    import cut_seq_pkg::*;
#(
    parameter int VEC_W      = 41,
    parameter int OUT_W      = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vec_wr_en,
    input  logic [ADDR_W-1:0] vec_wr_addr,
    input  logic [VEC_W-1:0]  vec_wr_data,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic [VEC_W-1:0]  cut_in,
    input  logic [OUT_W-1:0]  cut_out,
    output logic              cap_valid,
    output logic [OUT_W-1:0]  cap_data,
    output logic [ADDR_W-1:0] cap_idx,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  signature
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [ADDR_W:0]  DEPTH_L     = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t state, state_nxt;

    logic [VEC_W-1:0]  vec_tab [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   num_lat;
    logic              loop_lat;
    logic [CNT_W-1:0]  settle_cnt;

    logic start_acc;
    logic bad_num;
    logic last_vec;
    logic settle_done;

    assign start_acc   = (state == S_IDLE) && start && !stop;
    assign bad_num     = (num_vec == '0) || (num_vec > DEPTH_L);
    assign last_vec    = ({1'b0, idx} == (num_lat - 1'b1));
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign busy        = (state == S_APPLY) || (state == S_SETTLE)
                      || (state == S_CAPTURE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_acc) begin
                    state_nxt = bad_num ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: begin
                state_nxt = stop ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
                if (stop) begin
                    state_nxt = S_DONE;
                end else if (settle_done) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (stop || (last_vec && !loop_lat)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_APPLY;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            num_lat    <= '0;
            loop_lat   <= 1'b0;
            settle_cnt <= '0;
            cut_in     <= '0;
            cap_valid  <= 1'b0;
            cap_data   <= '0;
            cap_idx    <= '0;
            pass_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cap_valid <= (state == S_CAPTURE);
            done      <= (state == S_DONE);

            if (start_acc) begin
                num_lat  <= num_vec;
                loop_lat <= loop_en;
                idx      <= '0;
                pass_cnt <= '0;
            end

            if (state == S_APPLY) begin
                cut_in     <= vec_tab[idx];
                settle_cnt <= '0;
            end

            if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            // A capture coinciding with stop still lands; a finished
            // pass is counted even if stop arrives on its last capture.
            if (state == S_CAPTURE) begin
                cap_data <= cut_out;
                cap_idx  <= idx;
                if (last_vec) begin
                    pass_cnt <= sat_inc(pass_cnt);
                    idx      <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Table is not reset; writes are locked out while a run is active.
    always_ff @(posedge clk) begin
        if (vec_wr_en && !busy && (32'(vec_wr_addr) < DEPTH)) begin
            vec_tab[vec_wr_addr] <= vec_wr_data;
        end
    end

`ifdef CUT_SEQ_MISR_EN
    cut_seq_misr #(
        .OUT_W (OUT_W)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (state == S_CAPTURE),
        .din (cut_out),
        .sig (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_cut_vector_sequencer.sv
// Directed/randomised bench for cut_vector_sequencer against a c499-style CUT model.
// Define CUT_SEQ_MISR_EN to also check the signature against a reference MISR.
module tb_cut_vector_sequencer;

    localparam int VEC_W  = 41;
    localparam int OUT_W  = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int SETTLE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              vec_wr_en;
    logic [ADDR_W-1:0] vec_wr_addr;
    logic [VEC_W-1:0]  vec_wr_data;
    logic [ADDR_W:0]   num_vec;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic [VEC_W-1:0]  cut_in;
    logic [OUT_W-1:0]  cut_out;
    logic              cap_valid;
    logic [OUT_W-1:0]  cap_data;
    logic [ADDR_W-1:0] cap_idx;
    logic [15:0]       pass_cnt;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  signature;

    always #5 clk = ~clk;

    cut_vector_sequencer #(
        .VEC_W      (VEC_W),
        .OUT_W      (OUT_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vec_wr_en   (vec_wr_en),
        .vec_wr_addr (vec_wr_addr),
        .vec_wr_data (vec_wr_data),
        .num_vec     (num_vec),
        .loop_en     (loop_en),
        .start       (start),
        .stop        (stop),
        .cut_in      (cut_in),
        .cut_out     (cut_out),
        .cap_valid   (cap_valid),
        .cap_data    (cap_data),
        .cap_idx     (cap_idx),
        .pass_cnt    (pass_cnt),
        .busy        (busy),
        .done        (done),
        .signature   (signature)
    );

    // c499-style single-error-correction: 32 data, 8 check, 1 enable bit.
    function automatic logic [31:0] cut_model(input logic [40:0] v);
        logic [31:0] d;
        logic [7:0]  syn;
        logic [31:0] m [8];
        m[0] = 32'h5555_5555; m[1] = 32'h3333_3333;
        m[2] = 32'h0F0F_0F0F; m[3] = 32'h00FF_00FF;
        m[4] = 32'h0000_FFFF; m[5] = 32'hFF00_FF00;
        m[6] = 32'hF0F0_F0F0; m[7] = 32'hCCCC_CCCC;
        d = v[31:0];
        for (int k = 0; k < 8; k++) syn[k] = (^(d & m[k])) ^ v[32+k];
        if (v[40] && syn != 8'h00) d[syn[4:0]] = ~d[syn[4:0]];
        return d;
    endfunction

    assign cut_out = cut_model(cut_in);

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int first_cap = -1;
    int cap_i_q[$];
    logic [OUT_W-1:0] cap_d_q[$];
    logic [VEC_W-1:0] shadow [DEPTH];

    function automatic logic [OUT_W-1:0] misr_ref(input int n);
        logic [31:0] s = '0;
        logic fb;
        for (int i = 0; i < n; i++) begin
            fb = ^(s & 32'h8020_0003);
            s = {s[30:0], fb} ^ cut_model(shadow[i]);
        end
        return s;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[VEC_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cap_valid === 1'b1) begin
            if (cap_i_q.size() == 0) first_cap = cyc;
            cap_i_q.push_back(int'(cap_idx));
            cap_d_q.push_back(cap_data);
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic clear_obs();
        cap_i_q.delete();
        cap_d_q.delete();
        done_cnt = 0;
        first_cap = -1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", 64'(done_cnt != 0), 64'd1);
        step();
        step();
    endtask

    task automatic wait_caps(input int want, input int budget);
        int n = 0;
        while (cap_i_q.size() < want && n < budget) begin
            step();
            n++;
        end
        check("caps_within_budget", 64'(cap_i_q.size() >= want), 64'd1);
    endtask

    task automatic start_run(input int n, input logic lp);
        num_vec = (ADDR_W + 1)'(n);
        loop_en = lp;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_cap(input string tag, input int i, input int exp_idx);
        int oi;
        logic [OUT_W-1:0] od;
        oi = (i < cap_i_q.size()) ? cap_i_q[i] : -1;
        od = (i < cap_d_q.size()) ? cap_d_q[i] : 'x;
        check({tag, "_idx"}, 64'(oi), 64'(exp_idx));
        check({tag, "_data"}, 64'(od), 64'(cut_model(shadow[exp_idx])));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cut_in"}, 64'(cut_in), 64'd0);
        check({tag, "_cap_valid"}, 64'(cap_valid), 64'd0);
        check({tag, "_cap_data"}, 64'(cap_data), 64'd0);
        check({tag, "_cap_idx"}, 64'(cap_idx), 64'd0);
        check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_signature"}, 64'(signature), 64'd0);
    endtask

    initial begin
        logic [OUT_W-1:0] exp_sig;
        logic [VEC_W-1:0] v;
        int start_cyc;

        rst = 1'b1;
        vec_wr_en = 1'b0;
        vec_wr_addr = '0;
        vec_wr_data = '0;
        num_vec = '0;
        loop_en = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_zero_outputs("reset");

        for (int i = 0; i < DEPTH; i++) begin
            v = rand_vec();
            v[40] = i[0];
            shadow[i] = v;
            vec_wr_en = 1'b1;
            vec_wr_addr = ADDR_W'(i);
            vec_wr_data = v;
            step();
        end
        vec_wr_en = 1'b0;

        // Full single pass, with a stray start while busy.
        clear_obs();
        start_cyc = cyc;
        start_run(8, 1'b0);
        check("busy_after_start", 64'(busy), 64'd1);
        step();
        step();
        num_vec = 4'd2;
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(200);
        check("latency_first_cap", 64'(first_cap - start_cyc), 64'(SETTLE + 3));
        check("pass1_count", 64'(cap_i_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) check_cap("pass1", i, i);
        check("pass1_pass_cnt", 64'(pass_cnt), 64'd1);
        check("pass1_done_cnt", 64'(done_cnt), 64'd1);
        check("pass1_busy_end", 64'(busy), 64'd0);
        check("pass1_cut_in_hold", 64'(cut_in), 64'(shadow[7]));
`ifdef CUT_SEQ_MISR_EN
        exp_sig = misr_ref(8);
`else
        exp_sig = '0;
`endif
        check("pass1_signature", 64'(signature), 64'(exp_sig));

        // Looping 3-vector pass, stopped after the seventh capture.
        clear_obs();
        start_run(3, 1'b1);
        wait_caps(7, 300);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(50);
        check("loop_count", 64'(cap_i_q.size()), 64'd7);
        for (int i = 0; i < 7; i++) check_cap("loop", i, i % 3);
        check("loop_pass_cnt", 64'(pass_cnt), 64'd2);
        check("loop_done_cnt", 64'(done_cnt), 64'd1);

        // Empty and oversize runs go straight to done.
        clear_obs();
        start_run(0, 1'b0);
        check("nv0_done_c1", 64'(done), 64'd0);
        check("nv0_busy_c1", 64'(busy), 64'd0);
        check("nv0_pass_clr", 64'(pass_cnt), 64'd0);
        step();
        check("nv0_done_c2", 64'(done), 64'd1);
        step();
        check("nv0_no_caps", 64'(cap_i_q.size()), 64'd0);
        check("nv0_done_cnt", 64'(done_cnt), 64'd1);

        clear_obs();
        start_run(9, 1'b0);
        step();
        step();
        check("nv9_no_caps", 64'(cap_i_q.size()), 64'd0);
        check("nv9_done_cnt", 64'(done_cnt), 64'd1);

        // start and stop together in idle: nothing happens.
        clear_obs();
        num_vec = 4'd4;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("ss_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) step();
        check("ss_busy_later", 64'(busy), 64'd0);
        check("ss_no_caps", 64'(cap_i_q.size()), 64'd0);
        check("ss_no_done", 64'(done_cnt), 64'd0);

        // A write while busy must be dropped.
        clear_obs();
        start_run(8, 1'b1);
        for (int i = 0; i < 5; i++) step();
        vec_wr_en = 1'b1;
        vec_wr_addr = 3'd2;
        vec_wr_data = ~shadow[2];
        step();
        vec_wr_en = 1'b0;
        wait_caps(16, 400);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(50);
        check_cap("wrbusy_p1", 2, 2);
        check_cap("wrbusy_p2", 10, 2);
        check("wrbusy_pass_cnt", 64'(pass_cnt), 64'd2);

        // Reset in the middle of the settle window.
        clear_obs();
        start_run(8, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero_outputs("midrst");
        for (int i = 0; i < 4; i++) step();
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        check("midrst_no_caps", 64'(cap_i_q.size()), 64'd0);

        // Write and start in the same idle cycle: run sees new data.
        clear_obs();
        v = rand_vec();
        v[40] = 1'b1;
        vec_wr_en = 1'b1;
        vec_wr_addr = 3'd0;
        vec_wr_data = v;
        shadow[0] = v;
        start_run(1, 1'b0);
        vec_wr_en = 1'b0;
        wait_done(50);
        check("wrstart_count", 64'(cap_i_q.size()), 64'd1);
        check_cap("wrstart", 0, 0);
        check("wrstart_pass_cnt", 64'(pass_cnt), 64'd1);

        // Restarted full pass: signature must be rebuilt from zero.
        clear_obs();
        start_run(8, 1'b0);
        wait_done(200);
        check("pass2_count", 64'(cap_i_q.size()), 64'd8);
        check_cap("pass2_last", 7, 7);
`ifdef CUT_SEQ_MISR_EN
        exp_sig = misr_ref(8);
`else
        exp_sig = '0;
`endif
        check("pass2_signature", 64'(signature), 64'(exp_sig));
        step();
        check("pass2_signature_stable", 64'(signature), 64'(exp_sig));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
